// File: rtl/vedic_pkg.sv
// ---------------------------------------------------------------------------
// vedic_pkg
// Shared helpers for the pipelined Vedic multiplier:
//   clog2        - integer ceiling log2, usable in constant expressions
//   level_width  - operand width handled at a given tree level (level 0 = 2 bits)
//   stage_count  - number of pipeline stages for a given operand width
//   vedic2x2     - the 2-bit Urdhva-Tiryagbhyam cell (AND terms + two half adders)
// ---------------------------------------------------------------------------
package vedic_pkg;

   typedef logic [3:0] prod2x2_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

   // Level 0 multiplies 2-bit chunks, and each level doubles the operand width.
   function automatic int level_width(input int lvl);
      return 2 << lvl;
   endfunction

   // One stage for the 2x2 cells plus one per combine level; the last
   // combine stage also applies the sign.
   function automatic int stage_count(input int width);
      return clog2(width);
   endfunction

   // Vertical and crosswise 2x2 product. The crosswise terms meet in one
   // half adder, and that carry joins the vertical high term in another.
   function automatic prod2x2_t vedic2x2(input logic [1:0] x, input logic [1:0] y);
      logic t_cross0;
      logic t_cross1;
      logic t_high;
      logic sum1;
      logic carry1;
      logic sum2;
      logic carry2;
      t_cross0 = x[1] & y[0];
      t_cross1 = x[0] & y[1];
      t_high   = x[1] & y[1];
      sum1     = t_cross0 ^ t_cross1;
      carry1   = t_cross0 & t_cross1;
      sum2     = t_high ^ carry1;
      carry2   = t_high & carry1;
      return {carry2, sum2, sum1, x[0] & y[0]};
   endfunction

endpackage

// File: rtl/vedic_combine.sv
// ---------------------------------------------------------------------------
// vedic_combine
// Combines four products of K-bit operand halves into the full product of
// the 2K-bit operands: prod = ll + ((lh + hl) << K) + (hh << 2K).
// Purely combinational; the pipeline registers live in the top module.
// Ports:
//   ll, lh, hl, hh  in  2K bits  sub-products (first letter = a half, second = b half)
//   prod            out 4K bits  exact product, no truncation
// ---------------------------------------------------------------------------
module vedic_combine #(
   parameter int K = 2
) (
   input  logic [2*K-1:0] ll,
   input  logic [2*K-1:0] lh,
   input  logic [2*K-1:0] hl,
   input  logic [2*K-1:0] hh,
   output logic [4*K-1:0] prod
);

   logic [4*K-1:0] term_x;
   logic [3*K-1:0] term_y;
   logic [3*K-1:0] term_z;
   logic [3*K-1:0] maj;
   logic [4*K-1:0] sum_vec;
   logic [4*K-1:0] carry_vec;

   // ll and hh never overlap, so they pack into one 4K-bit term. The two
   // crosswise terms only reach bit 3K-1, so above that the 3:2 layer just
   // passes hh through and its majority is confined to the low 3K bits. The
   // final sum cannot exceed 4K bits because the true product fits there.
   always_comb begin
      term_x    = {hh, ll};
      term_y    = {lh, {K{1'b0}}};
      term_z    = {hl, {K{1'b0}}};
      maj       = (term_x[3*K-1:0] & term_y) | (term_x[3*K-1:0] & term_z) | (term_y & term_z);
      sum_vec   = {term_x[4*K-1:3*K], term_x[3*K-1:0] ^ term_y ^ term_z};
      carry_vec = {{(K-1){1'b0}}, maj, 1'b0};
      prod      = sum_vec + carry_vec;
   end

endmodule

// File: rtl/vedic_mult_pipe.sv
// ---------------------------------------------------------------------------
// vedic_mult_pipe
// Pipelined Urdhva-Tiryagbhyam multiplier, WIDTH x WIDTH -> 2*WIDTH, with
// signed/unsigned mode per operand pair and a valid/ready stream interface.
// Latency is log2(WIDTH) cycles; the whole pipe stalls when the output is
// held and not accepted.
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous active-high reset
//   in_valid   in   1          a/b/is_signed valid
//   in_ready   out  1          operands accepted this cycle when in_valid
//   a, b       in   WIDTH      multiplicand, multiplier
//   is_signed  in   1          1: two's complement, 0: unsigned
//   out_valid  out  1          p holds a product
//   out_ready  in   1          downstream takes p this cycle
//   p          out  2*WIDTH    product
// ---------------------------------------------------------------------------
module vedic_mult_pipe
   import vedic_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p
);

   localparam int LATENCY = stage_count(WIDTH);
   localparam int N0      = WIDTH / 2;
   localparam int P0_BITS = N0 * N0 * 4;

   logic                 advance;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic                 neg_in;
   logic [P0_BITS-1:0]   prod0_new;
   logic [P0_BITS-1:0]   prod0_d;
   logic [P0_BITS-1:0]   prod0_q;
   logic [LATENCY-1:0]   valid_d;
   logic [LATENCY-1:0]   valid_q;
   logic [LATENCY-2:0]   neg_d;
   logic [LATENCY-2:0]   neg_q;

   // The pipe moves as one unit: it advances whenever the output slot is
   // empty or being drained, which is also exactly when a new pair fits.
   always_comb begin
      advance   = !valid_q[LATENCY-1] | out_ready;
      in_ready  = advance;
      out_valid = valid_q[LATENCY-1];
   end

   // Signed pairs are reduced to magnitudes so the tree is always unsigned.
   // Negating the most negative value wraps to 2^(WIDTH-1), which is the
   // correct magnitude when read back as unsigned.
   always_comb begin
      a_mag  = a;
      b_mag  = b;
      neg_in = 1'b0;
      if (is_signed) begin
         if (a[WIDTH-1]) begin
            a_mag = -a;
         end
         if (b[WIDTH-1]) begin
            b_mag = -b;
         end
         neg_in = a[WIDTH-1] ^ b[WIDTH-1];
      end
   end

   // Every 2-bit chunk of a against every 2-bit chunk of b; product (i,j)
   // sits at slot i*N0+j where i indexes a.
   for (genvar i = 0; i < N0; i++) begin : g_base_row
      for (genvar j = 0; j < N0; j++) begin : g_base_col
         assign prod0_new[(i*N0+j)*4 +: 4] = vedic2x2(a_mag[2*i +: 2], b_mag[2*j +: 2]);
      end
   end

   // Valid and sign bits ride along with the data; bubbles shift too.
   always_comb begin
      valid_d = valid_q;
      neg_d   = neg_q;
      prod0_d = prod0_q;
      if (advance) begin
         valid_d[0] = in_valid;
         neg_d[0]   = neg_in;
         prod0_d    = prod0_new;
         for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
         end
         for (int i = 1; i < LATENCY - 1; i++) begin
            neg_d[i] = neg_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         neg_q   <= '0;
         prod0_q <= '0;
      end else begin
         valid_q <= valid_d;
         neg_q   <= neg_d;
         prod0_q <= prod0_d;
      end
   end

   // Each stage merges 2x2 blocks of sub-products into products of operands
   // twice as wide. The final stage holds a single 2*WIDTH product and
   // applies the sign there, so p comes straight from a register.
   for (genvar s = 1; s < LATENCY; s++) begin : g_stage
      localparam int K        = level_width(s - 1);
      localparam int NI       = WIDTH / K;
      localparam int NO       = NI / 2;
      localparam int IN_BITS  = NI * NI * 2 * K;
      localparam int OUT_BITS = NO * NO * 4 * K;
      localparam bit LAST     = (s == LATENCY - 1);

      logic [IN_BITS-1:0]  prod_in;
      logic [OUT_BITS-1:0] prod_new;
      logic [OUT_BITS-1:0] prod_d;
      logic [OUT_BITS-1:0] prod_q;

      if (s == 1) begin : g_from_base
         assign prod_in = prod0_q;
      end else begin : g_from_prev
         assign prod_in = g_stage[s-1].prod_q;
      end

      for (genvar i = 0; i < NO; i++) begin : g_row
         for (genvar j = 0; j < NO; j++) begin : g_col
            vedic_combine #(
               .K(K)
            ) u_combine (
               .ll   (prod_in[((2*i)*NI + 2*j)*2*K     +: 2*K]),
               .lh   (prod_in[((2*i)*NI + 2*j+1)*2*K   +: 2*K]),
               .hl   (prod_in[((2*i+1)*NI + 2*j)*2*K   +: 2*K]),
               .hh   (prod_in[((2*i+1)*NI + 2*j+1)*2*K +: 2*K]),
               .prod (prod_new[(i*NO + j)*4*K +: 4*K])
            );
         end
      end

      always_comb begin
         prod_d = prod_q;
         if (advance) begin
            if (LAST && neg_q[s-1]) begin
               prod_d = -prod_new;
            end else begin
               prod_d = prod_new;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            prod_q <= '0;
         end else begin
            prod_q <= prod_d;
         end
      end
   end

   assign p = g_stage[LATENCY-1].prod_q;

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_vedic_mult_pipe
// Drives a WIDTH=4 and a WIDTH=8 instance of vedic_mult_pipe and compares
// every product against an integer-arithmetic reference.
// ---------------------------------------------------------------------------
module tb_vedic_mult_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        in_valid4  = 1'b0;
   logic        in_ready4;
   logic [3:0]  a4         = '0;
   logic [3:0]  b4         = '0;
   logic        is_signed4 = 1'b0;
   logic        out_valid4;
   logic        out_ready4 = 1'b0;
   logic [7:0]  p4;

   logic        in_valid8  = 1'b0;
   logic        in_ready8;
   logic [7:0]  a8         = '0;
   logic [7:0]  b8         = '0;
   logic        is_signed8 = 1'b0;
   logic        out_valid8;
   logic        out_ready8 = 1'b0;
   logic [15:0] p8;

   int checks = 0;
   int errors = 0;

   vedic_mult_pipe #(.WIDTH(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .a         (a4),
      .b         (b4),
      .is_signed (is_signed4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .p         (p4)
   );

   vedic_mult_pipe #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .a         (a8),
      .b         (b8),
      .is_signed (is_signed8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .p         (p8)
   );

   always #5 clk = ~clk;

   // Reference product: interpret operands as integers, multiply, keep 2*w bits.
   function automatic logic [15:0] ref_mult(input int w, input logic [7:0] x,
                                            input logic [7:0] y, input logic sgn);
      longint xs;
      longint ys;
      longint pr;
      xs = longint'(x);
      ys = longint'(y);
      if (sgn) begin
         if (x[w-1]) xs = xs - (longint'(1) << w);
         if (y[w-1]) ys = ys - (longint'(1) << w);
      end
      pr = xs * ys;
      return 16'(pr & ((longint'(1) << (2 * w)) - 1));
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      in_valid4 = 1'b0; in_valid8 = 1'b0;
      out_ready4 = 1'b0; out_ready8 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid4: got %b want 0", out_valid4); end
      checks++;
      if (p4 !== 8'h00) begin errors++; $display("[TB] FAIL reset_p4: got %h want 00", p4); end
      checks++;
      if (out_valid8 !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid8: got %b want 0", out_valid8); end
      checks++;
      if (p8 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_p8: got %h want 0000", p8); end
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready4 !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready4: got %b want 1", in_ready4); end
      checks++;
      if (in_ready8 !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready8: got %b want 1", in_ready8); end
   endtask

   task automatic test_directed4();
      logic [3:0] dir_a [3];
      logic [3:0] dir_b [3];
      logic       dir_s [3];
      logic [7:0] dir_p [3];
      dir_a = '{4'hF, 4'h8, 4'h8};
      dir_b = '{4'hF, 4'h8, 4'h7};
      dir_s = '{1'b0, 1'b1, 1'b1};
      dir_p = '{8'hE1, 8'h40, 8'hC8};
      out_ready4 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a4 = dir_a[i]; b4 = dir_b[i]; is_signed4 = dir_s[i]; in_valid4 = 1'b1;
         #1;
         checks++;
         if (in_ready4 !== 1'b1) begin errors++; $display("[TB] FAIL dir_accept[%0d]: got %b want 1", i, in_ready4); end
         @(posedge clk);
         #1;
         in_valid4 = 1'b0;
         #1;
         checks++;
         if (out_valid4 !== 1'b0) begin errors++; $display("[TB] FAIL dir_early[%0d]: out_valid got %b want 0", i, out_valid4); end
         @(posedge clk);
         #2;
         checks++;
         if (out_valid4 !== 1'b1) begin errors++; $display("[TB] FAIL dir_latency[%0d]: out_valid got %b want 1", i, out_valid4); end
         checks++;
         if (p4 !== dir_p[i]) begin errors++; $display("[TB] FAIL dir_product[%0d]: got %h want %h", i, p4, dir_p[i]); end
         @(posedge clk);
         #2;
         checks++;
         if (out_valid4 !== 1'b0) begin errors++; $display("[TB] FAIL dir_dup[%0d]: out_valid got %b want 0", i, out_valid4); end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_stream8();
      logic [15:0] exp_q [$];
      int          acc_q [$];
      logic [7:0]  cur_a;
      logic [7:0]  cur_b;
      logic        cur_s;
      logic [15:0] exp_p;
      int          acc_c;
      int          sent;
      int          got;
      sent = 0; got = 0;
      cur_a = 8'($urandom); cur_b = 8'($urandom); cur_s = 1'($urandom_range(0, 1));
      out_ready8 = 1'b1;
      for (int c = 0; c < 400 && got < 256; c++) begin
         in_valid8 = (sent < 256); a8 = cur_a; b8 = cur_b; is_signed8 = cur_s;
         #1;
         if (out_valid8 && out_ready8) begin
            got++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("[TB] FAIL stream_extra: got p=%h want no output", p8);
            end else begin
               exp_p = exp_q.pop_front();
               acc_c = acc_q.pop_front();
               if (p8 !== exp_p) begin errors++; $display("[TB] FAIL stream_product #%0d: got %h want %h", got, p8, exp_p); end
               checks++;
               if (c - acc_c != 3) begin errors++; $display("[TB] FAIL stream_latency #%0d: got %0d want 3", got, c - acc_c); end
            end
         end
         if (in_valid8 && in_ready8) begin
            exp_q.push_back(ref_mult(8, cur_a, cur_b, cur_s));
            acc_q.push_back(c);
            sent++;
            cur_a = 8'($urandom); cur_b = 8'($urandom); cur_s = 1'($urandom_range(0, 1));
         end
         @(posedge clk);
         #1;
      end
      in_valid8 = 1'b0;
      checks++;
      if (got != 256 || exp_q.size() != 0) begin
         errors++; $display("[TB] FAIL stream_count: got %0d results (%0d pending) want 256", got, exp_q.size());
      end
   endtask

   task automatic test_stall8();
      logic [15:0] exp_q [$];
      logic [7:0]  cur_a;
      logic [7:0]  cur_b;
      logic        cur_s;
      logic [15:0] exp_p;
      logic [15:0] held_p;
      int          sent;
      int          got;
      sent = 0; got = 0; held_p = '0;
      cur_a = 8'($urandom); cur_b = 8'($urandom); cur_s = 1'($urandom_range(0, 1));
      for (int c = 0; c < 40; c++) begin
         in_valid8  = (sent < 12); a8 = cur_a; b8 = cur_b; is_signed8 = cur_s;
         out_ready8 = !(c >= 6 && c < 11);
         #1;
         if (c == 6) held_p = p8;
         if (c >= 6 && c < 11) begin
            checks++;
            if (in_ready8 !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready c=%0d: got %b want 0", c, in_ready8); end
            checks++;
            if (out_valid8 !== 1'b1) begin errors++; $display("[TB] FAIL stall_out_valid c=%0d: got %b want 1", c, out_valid8); end
            checks++;
            if (p8 !== held_p) begin errors++; $display("[TB] FAIL stall_p_stable c=%0d: got %h want %h", c, p8, held_p); end
         end
         if (out_valid8 && out_ready8) begin
            got++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("[TB] FAIL stall_extra: got p=%h want no output", p8);
            end else begin
               exp_p = exp_q.pop_front();
               if (p8 !== exp_p) begin errors++; $display("[TB] FAIL stall_product #%0d: got %h want %h", got, p8, exp_p); end
            end
         end
         if (in_valid8 && in_ready8) begin
            exp_q.push_back(ref_mult(8, cur_a, cur_b, cur_s));
            sent++;
            cur_a = 8'($urandom); cur_b = 8'($urandom); cur_s = 1'($urandom_range(0, 1));
         end
         @(posedge clk);
         #1;
      end
      in_valid8 = 1'b0;
      checks++;
      if (got != 12 || exp_q.size() != 0) begin
         errors++; $display("[TB] FAIL stall_count: got %0d results (%0d pending) want 12", got, exp_q.size());
      end
   endtask

   task automatic test_reset_flight();
      out_ready8 = 1'b1;
      for (int c = 0; c < 3; c++) begin
         in_valid8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); is_signed8 = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      in_valid8 = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid8 !== 1'b0) begin errors++; $display("[TB] FAIL flight_out_valid: got %b want 0", out_valid8); end
      checks++;
      if (p8 !== 16'h0000) begin errors++; $display("[TB] FAIL flight_p: got %h want 0000", p8); end
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_valid8 !== 1'b0) begin errors++; $display("[TB] FAIL flight_stale c=%0d: out_valid got %b want 0", c, out_valid8); end
      end
   endtask

   task automatic test_exhaustive4();
      logic [7:0] exp_q [$];
      logic [8:0] op;
      logic [7:0] exp_p;
      int         sent;
      int         got;
      sent = 0; got = 0;
      for (int c = 0; c < 6000 && got < 512; c++) begin
         op = 9'(sent);
         in_valid4  = (sent < 512) && ($urandom_range(0, 3) != 0);
         out_ready4 = 1'($urandom_range(0, 1));
         is_signed4 = op[8]; a4 = op[7:4]; b4 = op[3:0];
         #1;
         if (out_valid4 && out_ready4) begin
            got++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("[TB] FAIL exh_extra: got p=%h want no output", p4);
            end else begin
               exp_p = exp_q.pop_front();
               if (p4 !== exp_p) begin errors++; $display("[TB] FAIL exh_product #%0d: got %h want %h", got, p4, exp_p); end
            end
         end
         if (in_valid4 && in_ready4) begin
            exp_q.push_back(8'(ref_mult(4, {4'h0, op[7:4]}, {4'h0, op[3:0]}, op[8])));
            sent++;
         end
         @(posedge clk);
         #1;
      end
      in_valid4 = 1'b0;
      checks++;
      if (got != 512 || exp_q.size() != 0) begin
         errors++; $display("[TB] FAIL exh_count: got %0d results (%0d pending) want 512", got, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_directed4();
      test_stream8();
      test_stall8();
      test_reset_flight();
      test_exhaustive4();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   // Guards against a hung pipeline.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
